// File: rtl/qos_arbiter.sv
// Weighted round-robin pop arbiter for the four QoS class FIFOs.
// Combinational grant from registered credits and round-robin pointer.
module qos_arbiter #(
  parameter int W0 = 4,
  parameter int W1 = 3,
  parameter int W2 = 2,
  parameter int W3 = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] fifo_empty,
  input  logic       dest_afull,
  output logic [3:0] pop,
  output logic       push,
  output logic [1:0] grant_id,
  output logic [3:0] credit0,
  output logic [3:0] credit1,
  output logic [3:0] credit2,
  output logic [3:0] credit3
);

  localparam logic [3:0] WT [4] = '{4'(W0), 4'(W1), 4'(W2), 4'(W3)};

  logic [3:0] cred [4];
  logic [1:0] ptr;

  logic [3:0] c_raw;
  logic [3:0] cand;
  logic [3:0] eff [4];
  logic       refill;
  logic       go;
  logic       found;
  logic [1:0] g;
  logic [3:0] nc;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      c_raw[i] = !fifo_empty[i] && (cred[i] != 4'd0);
    end
    refill = (c_raw == 4'd0) && (fifo_empty != 4'hF);
    cand   = refill ? ~fifo_empty : c_raw;
    for (int i = 0; i < 4; i++) begin
      eff[i] = refill ? WT[i] : cred[i];
    end
    // reset gates the outputs so they drop without waiting for a clock
    go = !reset && !dest_afull && (fifo_empty != 4'hF);
    found = 1'b0;
    g     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!found && cand[2'(ptr + 2'(k))]) begin
        found = 1'b1;
        g     = 2'(ptr + 2'(k));
      end
    end
    nc = eff[g] - 4'd1;
  end

  assign pop      = go ? (4'b0001 << g) : 4'b0000;
  assign push     = go;
  assign grant_id = go ? g : 2'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cred[i] <= WT[i];
      end
      ptr <= 2'd0;
    end else if (go) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) == g) begin
          cred[i] <= nc;
        end else if (refill) begin
          cred[i] <= WT[i];
        end
      end
      ptr <= (nc != 4'd0) ? g : g + 2'd1;
    end
  end

  assign credit0 = cred[0];
  assign credit1 = cred[1];
  assign credit2 = cred[2];
  assign credit3 = cred[3];

endmodule

// File: tb/tb_qos_arbiter.sv
// Directed vector bench for qos_arbiter.
// Each record is one clock: inputs, expected grant, credits after the edge.
module tb_qos_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fifo_empty;
  logic       dest_afull;
  logic [3:0] pop;
  logic       push;
  logic [1:0] grant_id;
  logic [3:0] credit0, credit1, credit2, credit3;

  qos_arbiter dut (
    .clk(clk),
    .reset(reset),
    .fifo_empty(fifo_empty),
    .dest_afull(dest_afull),
    .pop(pop),
    .push(push),
    .grant_id(grant_id),
    .credit0(credit0),
    .credit1(credit1),
    .credit2(credit2),
    .credit3(credit3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  fe;
    logic        af;
    logic        gnt;
    logic [1:0]  gid;
    logic [15:0] cr;
  } vec_t;

  vec_t vq[$];
  int   n_run = 0;
  int   n_fail = 0;

  function automatic logic [15:0] creds();
    return {credit0, credit1, credit2, credit3};
  endfunction

  task automatic add(input logic rst, input logic [3:0] fe,
                     input logic af, input logic gnt,
                     input logic [1:0] gid, input logic [15:0] cr);
    vec_t v;
    v = '{rst, fe, af, gnt, gid, cr};
    vq.push_back(v);
  endtask

  task automatic chk_out(input string nm, input logic gnt,
                         input logic [1:0] gid);
    logic [3:0] ep;
    ep = gnt ? (4'b0001 << gid) : 4'b0000;
    n_run++;
    if (pop !== ep || push !== gnt || grant_id !== (gnt ? gid : 2'd0)) begin
      n_fail++;
      $display("FAIL %s: pop=%b push=%b gid=%0d, want pop=%b push=%b gid=%0d",
               nm, pop, push, grant_id, ep, gnt, gnt ? gid : 2'd0);
    end
  endtask

  task automatic chk_cr(input string nm, input logic [15:0] cr);
    n_run++;
    if (creds() !== cr) begin
      n_fail++;
      $display("FAIL %s: credits=%h want %h", nm, creds(), cr);
    end
  endtask

  initial begin
    // all busy: 0,0,0,0,1,1,1,2,2,3 repeating, refill on cycle 11
    add(0, 4'h0, 0, 1, 0, 16'h3321);
    add(0, 4'h0, 0, 1, 0, 16'h2321);
    add(0, 4'h0, 0, 1, 0, 16'h1321);
    add(0, 4'h0, 0, 1, 0, 16'h0321);
    add(0, 4'h0, 0, 1, 1, 16'h0221);
    add(0, 4'h0, 0, 1, 1, 16'h0121);
    add(0, 4'h0, 0, 1, 1, 16'h0021);
    add(0, 4'h0, 0, 1, 2, 16'h0011);
    add(0, 4'h0, 0, 1, 2, 16'h0001);
    add(0, 4'h0, 0, 1, 3, 16'h0000);
    add(0, 4'h0, 0, 1, 0, 16'h3321);
    add(0, 4'h0, 0, 1, 0, 16'h2321);
    add(0, 4'h0, 0, 1, 0, 16'h1321);
    add(0, 4'h0, 0, 1, 0, 16'h0321);
    add(0, 4'h0, 0, 1, 1, 16'h0221);
    add(0, 4'h0, 0, 1, 1, 16'h0121);
    add(0, 4'h0, 0, 1, 1, 16'h0021);
    add(0, 4'h0, 0, 1, 2, 16'h0011);
    add(0, 4'h0, 0, 1, 2, 16'h0001);
    add(0, 4'h0, 0, 1, 3, 16'h0000);
    // only class 2: refill every second grant
    add(0, 4'hB, 0, 1, 2, 16'h4311);
    add(0, 4'hB, 0, 1, 2, 16'h4301);
    add(0, 4'hB, 0, 1, 2, 16'h4311);
    add(0, 4'hB, 0, 1, 2, 16'h4301);
    // all empty: hold, no refill
    add(0, 4'hF, 0, 0, 0, 16'h4301);
    add(0, 4'hF, 0, 0, 0, 16'h4301);
    // back-pressure after two class-0 grants
    add(1, 4'h0, 0, 0, 0, 16'h4321);
    add(0, 4'h0, 0, 1, 0, 16'h3321);
    add(0, 4'h0, 0, 1, 0, 16'h2321);
    for (int i = 0; i < 5; i++) add(0, 4'h0, 1, 0, 0, 16'h2321);
    add(0, 4'h0, 0, 1, 0, 16'h1321);
    add(0, 4'h0, 0, 1, 0, 16'h0321);
    add(0, 4'h0, 0, 1, 1, 16'h0221);
    // class 0 empties after one grant, returns before round ends
    add(1, 4'h0, 0, 0, 0, 16'h4321);
    add(0, 4'h0, 0, 1, 0, 16'h3321);
    add(0, 4'h1, 0, 1, 1, 16'h3221);
    add(0, 4'h1, 0, 1, 1, 16'h3121);
    add(0, 4'h1, 0, 1, 1, 16'h3021);
    add(0, 4'h1, 0, 1, 2, 16'h3011);
    add(0, 4'h1, 0, 1, 2, 16'h3001);
    add(0, 4'h1, 0, 1, 3, 16'h3000);
    add(0, 4'h0, 0, 1, 0, 16'h2000);
    add(0, 4'h0, 0, 1, 0, 16'h1000);
    add(0, 4'h0, 0, 1, 0, 16'h0000);
    add(0, 4'h0, 0, 1, 1, 16'h4221);
    // back-pressure with FIFOs also empty
    add(0, 4'hF, 1, 0, 0, 16'h4221);

    reset = 1'b1;
    fifo_empty = 4'h0;
    dest_afull = 1'b0;
    #1;
    chk_out("reset_out", 1'b0, 2'd0);
    chk_cr("reset_cr", 16'h4321);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst;
      fifo_empty = vq[i].fe;
      dest_afull = vq[i].af;
      #1;
      chk_out($sformatf("vec%0d_out", i), vq[i].gnt, vq[i].gid);
      @(posedge clk);
      #1;
      chk_cr($sformatf("vec%0d_cr", i), vq[i].cr);
    end

    // asynchronous reset in the middle of a burst
    @(negedge clk);
    reset = 1'b0;
    fifo_empty = 4'h0;
    dest_afull = 1'b0;
    #1;
    chk_out("pre_rst_out", 1'b1, 2'd1);
    @(posedge clk);
    #1;
    chk_cr("pre_rst_cr", 16'h4121);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst_out", 1'b0, 2'd0);
    chk_cr("async_rst_cr", 16'h4321);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_out("post_rst_out", 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
